// File: rtl/perf_counter_sampler_pkg.sv
// Shared definitions for the performance-counter sampler: FSM encoding,
// counter address map and the wrapping delta helper used by the readout.
package perf_counter_sampler_pkg;

  // Number of hardware performance counters in the window
  localparam int unsigned PERF_NUM_CNT = 10;

  // Counter addresses inside the performance-counter window
  localparam logic [31:0] PERF_BR_MISS     = 32'd0;
  localparam logic [31:0] PERF_IC_MISS     = 32'd1;
  localparam logic [31:0] PERF_DC_MISS     = 32'd2;
  localparam logic [31:0] PERF_LD_CNT      = 32'd3;
  localparam logic [31:0] PERF_ST_CNT      = 32'd4;
  localparam logic [31:0] PERF_INSTRET     = 32'd5;
  localparam logic [31:0] PERF_CYCLES      = 32'd6;
  localparam logic [31:0] PERF_FE_STALL    = 32'd7;
  localparam logic [31:0] PERF_BE_STALL    = 32'd8;
  localparam logic [31:0] PERF_TOTAL_STALL = 32'd9;

  // Sweep FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  // Counter difference modulo 2^32; a wrapped or restarted counter
  // yields the modular distance rather than a saturated value.
  function automatic logic [31:0] wrap_delta(input logic [31:0] cur,
                                             input logic [31:0] prev);
    return cur - prev;
  endfunction

endpackage

// File: rtl/perf_counter_sampler_if.sv
// Read-request bus between the sampler (initiator) and the data-port
// arbitration point. The response may be combinational on the request.
interface perf_counter_sampler_if;

  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_rdata,
    output mem_resp
  );

endinterface

// File: rtl/perf_period_timer.sv
// Free-running sweep interval timer. Counts while enabled, restarts on
// every sweep start, and pulses o_fire when it reaches period-1
// (a period of zero behaves like a period of one).
module perf_period_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_clear,
  input  logic [31:0] i_period,
  output logic        o_fire
);

  logic [31:0] r_timer;
  logic [31:0] w_limit;
  logic        w_hit;

  // Terminal count for the current period setting
  always_comb begin
    w_limit = 32'd0;
    if (i_period != 32'd0) begin
      w_limit = i_period - 32'd1;
    end else begin
      w_limit = 32'd0;
    end
    w_hit = i_en & (r_timer == w_limit);
  end

  // Interval counter: held at zero when disabled, restarts on fire or sweep start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= 32'd0;
    end else if (!i_en) begin
      r_timer <= 32'd0;
    end else if (i_clear || w_hit) begin
      r_timer <= 32'd0;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign o_fire = w_hit;

endmodule

// File: rtl/perf_counter_sampler.sv
// Performance-counter sampler: sweeps the counter window into a shadow
// bank, commits it atomically as a snapshot, and exposes snapshot and
// per-counter delta through a select port.
module perf_counter_sampler
  import perf_counter_sampler_pkg::*;
#(
  parameter int unsigned NUM_CNT   = PERF_NUM_CNT,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   periodic_en,
  input  logic [31:0]            period,
  input  logic                   clear_err,
  perf_counter_sampler_if.master mem,
  input  logic [3:0]             sel,
  output logic [31:0]            snap_data,
  output logic [31:0]            delta_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sample_count,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int unsigned IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_IDLE   = 2'(S_IDLE);
  localparam logic [1:0] ST_READ   = 2'(S_READ);
  localparam logic [1:0] ST_COMMIT = 2'(S_COMMIT);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_index;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_read;
  logic [31:0]       r_mem_address;
  logic              r_done;
  logic              r_pending;
  logic [15:0]       r_sample_count;
  logic              r_timeout_err;
  logic              r_overrun;

  logic [31:0] r_shadow [NUM_CNT];
  logic [31:0] r_snap   [NUM_CNT];
  logic [31:0] r_prev   [NUM_CNT];

  logic w_fire;
  logic w_busy;
  logic w_trigger;
  logic w_start_sweep;
  logic w_resp_ok;
  logic w_last;
  logic w_timeout;

  perf_period_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (periodic_en),
    .i_clear  (w_start_sweep),
    .i_period (period),
    .o_fire   (w_fire)
  );

  // Sweep-control decode: when a new sweep launches, response and timeout qualifiers
  always_comb begin
    w_busy        = (r_state != ST_IDLE);
    w_trigger     = start | w_fire | r_pending;
    w_resp_ok     = (r_state == ST_READ) & mem.mem_resp;
    w_last        = (r_index == IDX_W'(NUM_CNT - 1));
    w_timeout     = (r_state == ST_READ) & ~mem.mem_resp &
                    (r_wait == WAIT_W'(TIMEOUT - 1));
    w_start_sweep = 1'b0;
    case (r_state)
      ST_IDLE:   w_start_sweep = w_trigger;
      ST_COMMIT: w_start_sweep = r_pending | w_fire;
      default:   w_start_sweep = 1'b0;
    endcase
  end

  // Sweep FSM: request sequencing, address walk, wait counter and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_wait        <= '0;
      r_mem_read    <= 1'b0;
      r_mem_address <= BASE_ADDR;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_sweep) begin
            r_state       <= ST_READ;
            r_index       <= '0;
            r_wait        <= '0;
            r_mem_read    <= 1'b1;
            r_mem_address <= BASE_ADDR;
          end
        end
        ST_READ: begin
          if (mem.mem_resp) begin
            r_wait <= '0;
            if (w_last) begin
              // Last counter captured: release the bus and commit next cycle
              r_state       <= ST_COMMIT;
              r_index       <= '0;
              r_mem_read    <= 1'b0;
              r_mem_address <= BASE_ADDR;
              r_done        <= 1'b1;
            end else begin
              // Next address follows immediately, no idle cycle between reads
              r_index       <= r_index + IDX_W'(1);
              r_mem_address <= r_mem_address + 32'd1;
            end
          end else if (w_timeout) begin
            // Responder went silent: abandon the sweep, shadow is discarded
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_wait        <= '0;
            r_mem_read    <= 1'b0;
            r_mem_address <= BASE_ADDR;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_COMMIT: begin
          if (w_start_sweep) begin
            // A pending sweep chains directly into READ
            r_state       <= ST_READ;
            r_index       <= '0;
            r_wait        <= '0;
            r_mem_read    <= 1'b1;
            r_mem_address <= BASE_ADDR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_index       <= '0;
          r_wait        <= '0;
          r_mem_read    <= 1'b0;
          r_mem_address <= BASE_ADDR;
        end
      endcase
    end
  end

  // Shadow bank: capture each counter as its response arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        r_shadow[i] <= 32'd0;
      end
    end else if (w_resp_ok) begin
      r_shadow[r_index] <= mem.mem_rdata;
    end
  end

  // Snapshot/previous banks and sweep count: all entries move together in COMMIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        r_snap[i] <= 32'd0;
        r_prev[i] <= 32'd0;
      end
      r_sample_count <= 16'd0;
    end else if (r_state == ST_COMMIT) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        r_prev[i] <= r_snap[i];
        r_snap[i] <= r_shadow[i];
      end
      r_sample_count <= r_sample_count + 16'd1;
    end
  end

  // Pending sweep latch: one timer fire while busy is remembered, extra fires merge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (w_start_sweep) begin
      r_pending <= 1'b0;
    end else if (w_busy && w_fire) begin
      r_pending <= 1'b1;
    end
  end

  // Sticky error flags: a set event in the same cycle beats clear_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (clear_err) begin
        r_timeout_err <= 1'b0;
      end
      if (w_busy && w_fire) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Readout mux: out-of-range selects read as zero
  always_comb begin
    snap_data  = 32'd0;
    delta_data = 32'd0;
    if ({28'd0, sel} < NUM_CNT) begin
      snap_data  = r_snap[sel];
      delta_data = wrap_delta(r_snap[sel], r_prev[sel]);
    end else begin
      snap_data  = 32'd0;
      delta_data = 32'd0;
    end
  end

  assign mem.mem_read    = r_mem_read;
  assign mem.mem_address = r_mem_address;
  assign busy            = w_busy;
  assign done            = r_done;
  assign sample_count    = r_sample_count;
  assign timeout_err     = r_timeout_err;
  assign overrun         = r_overrun;

endmodule

// File: doc/perf_counter_sampler.md
Name: perf_counter_sampler

Overview:
- Initiator-side reader for the performance-counter window on the data port (counter addresses 0x0..0x9).
- Sweeps all counters on command or periodically, holding `read` and the address until `resp`, into a shadow bank.
- Commits the bank atomically as a snapshot and computes per-counter deltas against the previous snapshot.
- Sits between a debug/host requester and the data-port arbitration point; results are read through a select port.

Parameters:
- NUM_CNT, 10: number of counters swept (addresses BASE_ADDR .. BASE_ADDR+NUM_CNT-1).
- BASE_ADDR, 32'h0: first counter address.
- TIMEOUT, 64: maximum cycles waited for `mem_resp` on one address before the sweep aborts.

Ports:
- clk  in  1  Single clock; rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- start  in  1  Single-cycle sweep request; ignored while busy.
- periodic_en  in  1  Enables timer-driven sweeps.
- period  in  32  Sweep-start interval in cycles.
- clear_err  in  1  Clears the sticky `timeout_err` and `overrun` flags.
- mem_read  out  1  Read request to the counter window.
- mem_address  out  32  Read address.
- mem_rdata  in  32  Read data, valid when `mem_resp`=1.
- mem_resp  in  1  Response; may be asserted combinationally in the same cycle as the request.
- sel  in  4  Counter index for readout.
- snap_data  out  32  Committed snapshot value of counter `sel`.
- delta_data  out  32  `snap[sel] - prev[sel]`, modulo 2^32.
- busy  out  1  High in the READ and COMMIT states.
- done  out  1  One-cycle pulse in COMMIT.
- sample_count  out  16  Number of completed sweeps.
- timeout_err  out  1  Sticky flag: a sweep aborted on timeout.
- overrun  out  1  Sticky flag: the period elapsed while busy.

Behaviour:
- Reset (asynchronous, `reset_n`=0):
  - state=IDLE, `mem_read`=0, `mem_address`=BASE_ADDR.
  - shadow, snap and prev banks all 0.
  - `done`=0, `busy`=0, `sample_count`=0, `timeout_err`=0, `overrun`=0, period timer=0.
- Reset mid-sweep drops `mem_read` immediately; no commit occurs.
- FSM states: IDLE, READ, COMMIT.
- IDLE → READ:
  - Trigger is `start`=1 or timer-fire.
  - On entry: index=0, `mem_address`=BASE_ADDR, `mem_read`=1, wait counter=0.
- READ:
  - `mem_read` stays 1 and `mem_address`=BASE_ADDR+index is held stable until `mem_resp`=1 is sampled.
  - On each edge with `mem_resp`=1: shadow[index]<=`mem_rdata`, index++, address++, wait counter cleared.
  - Back-to-back reads carry no idle cycle between them.
  - After the response for index NUM_CNT-1: `mem_read`<=0, go to COMMIT.
- Timeout:
  - Wait counter increments each READ cycle without `mem_resp`.
  - When it reaches TIMEOUT-1 with no response: `mem_read`<=0, `timeout_err`<=1, return to IDLE.
  - Shadow contents are discarded; snap, prev and `sample_count` are unchanged.
- COMMIT (one cycle):
  - prev<=snap, snap<=shadow (all entries at once), `sample_count`++ (wraps 0xFFFF→0x0000), `done`=1.
  - Next state is READ if a sweep is pending, else IDLE.
- Latency with a zero-wait responder:
  - Start in cycle 0; `mem_read` high in cycles 1..NUM_CNT; COMMIT/`done` in cycle NUM_CNT+1; new data visible in cycle NUM_CNT+2.
- Period timer:
  - Runs while `periodic_en`=1 and resets to 0 on each sweep start.
  - Fires when timer==`period`-1; `period`=0 is treated as 1.
  - Cleared and held while `periodic_en`=0.
  - A fire while busy sets `overrun`<=1 and latches one pending sweep; multiple overruns latch only one.
- Start handling: `start` while busy is ignored (not latched). `start` and a fire in the same cycle produce one sweep.
- Readout (combinational from registers):
  - `snap_data`=snap[sel]; `delta_data`=snap[sel]-prev[sel] using 32-bit wrapping subtraction.
  - `sel`>=NUM_CNT gives 0 on both outputs.
  - After the first sweep, delta equals snap because prev=0.
  - A counter that wrapped or was reset by its source yields the modular difference; no saturation.
- `clear_err` clears both sticky flags. If a set event occurs in the same cycle, the set wins.

Decomposition:
- Shared package:
  - State enum {IDLE, READ, COMMIT}.
  - Counter address constants PERF_BR_MISS=0 .. PERF_TOTAL_STALL=9.
  - PERF_NUM_CNT=10.
- Sub-module: `perf_period_timer` (counter, fire, clear/enable), instantiated once.
- Banks and FSM stay in the top module.

Test Plan:
- Zero-wait responder returning `rdata`=addr*0x11, `start` at cycle 0:
  - `mem_address` goes 0..9 in cycles 1..10; `done` in cycle 11.
  - snap[3]=0x33, delta[3]=0x33, `sample_count`=1.
- Responder with 2 wait cycles per read:
  - Address held stable 3 cycles each; `done` in cycle 31; values correct.
- Second sweep:
  - Counter 5 moves from 0x00000010 to 0xFFFFFFF0 → delta 0xFFFFFFE0.
  - Counter 0 moves from 0xFFFFFFFE to 0x00000003 → delta 0x00000005.
- Responder silent at address 4:
  - `timeout_err`=1 after 64 wait cycles, `mem_read`=0, snap unchanged, `sample_count` unchanged.
  - `clear_err` → 0.
- `periodic_en`=1 with `period`=5 and a zero-wait responder: `overrun`=1, and sweeps run back-to-back with no IDLE cycle between COMMIT and READ.
- Assert `reset_n`=0 in cycle 4 of a sweep: `mem_read` drops the same cycle, all outputs 0, `done` never pulses.
